// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU
// control codes and the datapath mux select values.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Maps the FSM's coarse aluop plus instruction fields onto the ALU's 3-bit
// operation code. Purely combinational.
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) may subtract; addi ignores instr[30].
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore-style multicycle control unit for the RV32 subset (lw, sw, R, I, beq,
// jal). Sequences fetch, decode, memory access and writeback.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] aluop;
  logic       branch;
  logic       pcupdate;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    illegal_op = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RD2;
    aluop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        pcupdate  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BEQ: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset aborts whatever is in flight: no writes this cycle, FETCH decode shown.
    if (reset) begin
      state_d    = S_FETCH;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
      resultsrc  = RES_ALURESULT;
      alusrca    = SRCA_PC;
      alusrcb    = SRCB_FOUR;
      aluop      = ALUOP_ADD;
    end
  end

  assign pcwrite = pcupdate | (branch & zero);

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop     (aluop),
    .funct3    (funct3),
    .op5       (op[5]),
    .funct7b5  (funct7b5),
    .alucontrol(alucontrol)
  );

endmodule
